// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with its EX-stage sequencer for DIV/DIVU/REM/REMU.
// Holds the pipeline through stall_o and returns one registered result with a done pulse.
module div_sequencer #(
  parameter int XLEN      = 32,
  parameter bit FAST_PATH = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      funct3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] rem_q, quo_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            in_sign_a, in_sign_b;
  logic [XLEN-1:0] in_abs_a, in_abs_b;
  logic            b_zero, overflow, fast;
  logic [XLEN-1:0] raw_a, fast_result;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            stall;

  // Only the divide encodings (funct3[2]=1) are accepted; reset gates the combinational stall.
  assign accept = rst_n && (state_q == S_IDLE) && start_i && !flush_i && funct3_i[2];

  // Signs are folded with signedness, so unsigned ops always see sign=0 and |x|=x.
  assign in_sign_a = ~funct3_i[0] & op_a_i[XLEN-1];
  assign in_sign_b = ~funct3_i[0] & op_b_i[XLEN-1];
  assign in_abs_a  = in_sign_a ? (~op_a_i + 1'b1) : op_a_i;
  assign in_abs_b  = in_sign_b ? (~op_b_i + 1'b1) : op_b_i;

  assign raw_a    = sign_a_q ? (~a_q + 1'b1) : a_q;
  assign b_zero   = (b_q == '0);
  assign overflow = sign_a_q && sign_b_q && (a_q == MIN_NEG) && (b_q == {{(XLEN-1){1'b0}}, 1'b1});
  assign fast     = FAST_PATH && (b_zero || overflow);

  always_comb begin
    fast_result = '0;
    if (b_zero) fast_result = funct3_q[1] ? raw_a : ALL_ONE;
    else        fast_result = funct3_q[1] ? '0    : MIN_NEG;
  end

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, b_q};

  // A zero divisor keeps the all-ones quotient even when the dividend is negative.
  assign quo_fix = (sign_a_q ^ sign_b_q) && !b_zero ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = accept;
        if (accept) state_d = S_PREP;
      end
      S_PREP: begin
        stall   = 1'b1;
        state_d = fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (count_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        stall   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush in DONE is ignored: the result already belongs to the op leaving EX.
    if (flush_i && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            funct3_q <= funct3_i[1:0];
            a_q      <= in_abs_a;
            b_q      <= in_abs_b;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
          end
        end
        S_PREP: begin
          if (!flush_i) begin
            if (fast) begin
              result_q <= fast_result;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_q;
              count_q <= CW'(XLEN - 1);
            end
          end
        end
        S_CALC: begin
          rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        S_FIX: begin
          if (!flush_i) result_q <= funct3_q[1] ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign stall_o  = stall;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and small randomized self-checking bench for div_sequencer (XLEN=32, FAST_PATH=1).
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_sequencer #(.XLEN(32), .FAST_PATH(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M reference, independent of the restoring algorithm.
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f[1:0])
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Presents one op at a negedge (cycle 0), tracks stall until done, then drops start.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    bit seen, stall_ok;
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    #1;
    while (!seen && cyc < 100) begin
      if (done_o) begin
        seen = 1'b1;
        if (stall_o) stall_ok = 1'b0;
      end else begin
        if (!stall_o) stall_ok = 1'b0;
        @(negedge clk); #1;
        cyc++;
      end
    end
    check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " stall profile"}, {31'b0, stall_ok}, 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check({tag, " single pulse"}, {30'b0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    int n_done, first_c, second_c;
    logic [31:0] r1, r2, ra, rb;
    logic [2:0]  rf;
    bit idle_ok;

    // Reset state
    #12;
    check("reset outputs", {29'b0, stall_o, busy_o, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic iterative ops
    run_op("divu 100/7",     3'b101, 32'd100,        32'd7,          32'd14,         35);
    run_op("div -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35);
    run_op("rem -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35);
    run_op("remu fff9/2",    3'b111, 32'hFFFF_FFF9,  32'd2,          32'd1,          35);
    run_op("divu fff9/2",    3'b101, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  35);
    run_op("div 7/-2",       3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35);
    run_op("rem 7/-2",       3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          35);

    // Fast path corners
    run_op("divu 5/0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  2);
    run_op("remu 5/0",       3'b111, 32'd5,          32'd0,          32'd5,          2);
    run_op("div -5/0",       3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  2);
    run_op("rem -5/0",       3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2);
    run_op("div ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);
    run_op("rem ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);

    // Back-to-back with start held through DONE
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'd100; op_b_i = 32'hFFFF_FFF9;
    n_done = 0; first_c = -1; second_c = -1; r1 = '0; r2 = '0;
    for (int c = 0; c < 76; c++) begin
      if (c == 36) begin op_a_i = 32'd1000; op_b_i = 32'hFFFF_FFF6; end
      if (c == 72) start_i = 1'b0;
      #1;
      if (done_o) begin
        n_done++;
        if (n_done == 1) begin first_c = c; r1 = result_o; end
        else if (n_done == 2) begin second_c = c; r2 = result_o; end
      end
      @(negedge clk);
    end
    check("b2b pulse count", 32'(n_done), 32'd2);
    check("b2b first cycle", 32'(first_c), 32'd35);
    check("b2b spacing", 32'(second_c - first_c), 32'd36);
    check("b2b first result", r1, 32'hFFFF_FFF2);
    check("b2b second result", r2, 32'hFFFF_FF9C);
    #1;
    check("b2b idle after", {31'b0, busy_o}, 32'd0);

    // Flush at CALC cycle 10 (overall cycle 12)
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd3;
    repeat (12) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush to idle", {30'b0, busy_o, done_o}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done_o) n_done++;
    end
    check("flush no done", 32'(n_done), 32'd0);
    check("flush keeps result", result_o, 32'hFFFF_FF9C);
    run_op("after flush", 3'b101, 32'd1000, 32'd3, 32'd333, 35);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'hFFFF_FC18; op_b_i = 32'd7;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {29'b0, stall_o, busy_o, done_o}, 32'd0);
    check("mid reset result", result_o, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (busy_o || done_o || stall_o) idle_ok = 1'b0;
      @(negedge clk);
    end
    check("idle after reset", {31'b0, idle_ok}, 32'd1);
    run_op("div -1000/7", 3'b100, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 35);
    run_op("rem -1000/7", 3'b110, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, 35);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rf = 3'b100; end
      run_op("random", rf, ra, rb, ref_div(rf, ra, rb),
             (rb == 32'd0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 2 : 35);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
